// File: rtl/apu_pkg.sv
// ============================================================================
//  Module   : apu_pkg
//  Purpose  : Shared APU constants and types for the channel 1 frequency stage
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package apu_pkg;

  // Frequency / period-counter / sweep shift-register width
  localparam int CH1_FREQ_W = 11;

  // Sweep direction as presented on the inverted NR10 bit 3 line
  typedef enum logic {
    SWEEP_SUB = 1'b0,
    SWEEP_ADD = 1'b1
  } sweep_dir_e;

endpackage

`default_nettype wire

// File: rtl/ch1_freq_sweep_if.sv
// ============================================================================
//  Module   : ch1_freq_sweep_if
//  Purpose  : CPU register-write bus into the channel 1 frequency stage
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface ch1_freq_sweep_if;

  logic [7:0] d;       // CPU write data
  logic       apu_wr;  // CPU write strobe
  logic       ff13;    // NR13 selected (frequency low byte)
  logic       ff14;    // NR14 selected (frequency high bits)

  modport master (output d, apu_wr, ff13, ff14);
  modport slave  (input  d, apu_wr, ff13, ff14);

endinterface

`default_nettype wire

// File: rtl/ch1_period_counter.sv
// ============================================================================
//  Module   : ch1_period_counter
//  Purpose  : Free-running period counter; emits a one-clock pulse when it
//             wraps from all-ones and reloads from reload_val. Shared with
//             channel 2.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ch1_period_counter #(
  parameter int W = 11
) (
  input  wire logic         clk,
  input  wire logic         reset,
  input  wire logic         tick,
  input  wire logic         reload,
  input  wire logic [W-1:0] reload_val,
  output logic              pulse
);

  localparam logic [W-1:0] C_CNT_MAX = '1;

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;
  logic         pulse_q;
  logic         pulse_d;

  // Next count: reload beats a coincident tick and never emits a pulse
  always_comb begin
    cnt_d   = cnt_q;
    pulse_d = 1'b0;
    if (reload) begin
      cnt_d = reload_val;
    end else if (tick) begin
      if (cnt_q == C_CNT_MAX) begin
        cnt_d   = reload_val;
        pulse_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Counter and pulse registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q   <= '0;
      pulse_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      pulse_q <= pulse_d;
    end
  end

  assign pulse = pulse_q;

endmodule

`default_nettype wire

// File: rtl/ch1_freq_sweep.sv
// ============================================================================
//  Module   : ch1_freq_sweep
//  Purpose  : Channel 1 frequency register, period counter (copu duty-step
//             clock) and sweep shift/add/subtract with overflow flag (atys).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ch1_freq_sweep
  import apu_pkg::*;
#(
  parameter int FREQ_W = CH1_FREQ_W
) (
  input  wire logic              ajer_2mhz,
  input  wire logic              apu_reset,
  ch1_freq_sweep_if.slave        cpu,
  input  wire logic              nff10_d3,
  input  wire logic              ch1_freq_tick,
  input  wire logic              ch1_restart,
  input  wire logic              ch1_ld_shift,
  input  wire logic              ch1_shift_clk,
  input  wire logic              ch1_freq_upd1,
  input  wire logic              ch1_freq_upd2,
  output logic [FREQ_W-1:0]      freq,
  output logic                   copu,
  output logic                   atys
);

  // Strobe bit positions in the packed strobe vectors
  localparam int C_LD  = 0;
  localparam int C_SH  = 1;
  localparam int C_UP1 = 2;
  localparam int C_UP2 = 3;

  logic [FREQ_W-1:0] freq_q, freq_d;
  logic [FREQ_W-1:0] sreg_q, sreg_d;
  logic              atys_q, atys_d;
  logic [3:0]        strb_q;   // last sampled strobe levels
  logic [3:0]        fire_q;   // registered rising-edge pulses
  logic [3:0]        strb_w;
  logic [FREQ_W:0]   sum_w;
  logic              ovf_w;
  sweep_dir_e        dir_w;

  assign strb_w = {ch1_freq_upd2, ch1_freq_upd1, ch1_shift_clk, ch1_ld_shift};
  assign dir_w  = sweep_dir_e'(nff10_d3);

  // Sweep adder: one extra bit so an add carry-out flags overflow;
  // subtraction simply wraps and is never treated as overflow
  always_comb begin
    if (dir_w == SWEEP_ADD) begin
      sum_w = {1'b0, freq_q} + {1'b0, sreg_q};
    end else begin
      sum_w = {1'b0, freq_q} - {1'b0, sreg_q};
    end
    ovf_w = (dir_w == SWEEP_ADD) && sum_w[FREQ_W];
  end

  // Next-state for frequency, shift register and overflow flag; the CPU
  // write is applied last so it overrides a sweep commit bit-for-bit
  always_comb begin
    freq_d = freq_q;
    sreg_d = sreg_q;
    atys_d = atys_q;
    if (ch1_restart) begin
      atys_d = 1'b1;
    end else begin
      if (fire_q[C_UP1]) begin
        if (ovf_w) begin
          atys_d = 1'b0;
        end else begin
          freq_d = sum_w[FREQ_W-1:0];
        end
      end
      if (fire_q[C_UP2] && ovf_w) begin
        atys_d = 1'b0;
      end
      if (fire_q[C_LD]) begin
        sreg_d = freq_q;
      end else if (fire_q[C_SH]) begin
        sreg_d = {1'b0, sreg_q[FREQ_W-1:1]};
      end
      if (cpu.apu_wr && cpu.ff13) begin
        freq_d[7:0] = cpu.d;
      end
      if (cpu.apu_wr && cpu.ff14) begin
        freq_d[FREQ_W-1:8] = cpu.d[FREQ_W-9:0];
      end
    end
  end

  // State registers and strobe edge detectors (one cycle of latency)
  always_ff @(posedge ajer_2mhz or posedge apu_reset) begin
    if (apu_reset) begin
      freq_q <= '0;
      sreg_q <= '0;
      atys_q <= 1'b1;
      strb_q <= '0;
      fire_q <= '0;
    end else begin
      freq_q <= freq_d;
      sreg_q <= sreg_d;
      atys_q <= atys_d;
      strb_q <= strb_w;
      fire_q <= strb_w & ~strb_q;
    end
  end

  ch1_period_counter #(
    .W (FREQ_W)
  ) u_period (
    .clk        (ajer_2mhz),
    .reset      (apu_reset),
    .tick       (ch1_freq_tick),
    .reload     (ch1_restart),
    .reload_val (freq_q),
    .pulse      (copu)
  );

  assign freq = freq_q;
  assign atys = atys_q;

endmodule

`default_nettype wire

// File: tb/tb_ch1_freq_sweep.sv
// ============================================================================
//  Module   : tb_ch1_freq_sweep
//  Purpose  : Directed scoreboard bench for ch1_freq_sweep
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ch1_freq_sweep;
  import apu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        nff, tk, rs, ld, sh, u1, u2;
  logic [10:0] freq;
  logic        copu, atys;
  logic        stim_done = 1'b0;

  always #5 clk = ~clk;

  ch1_freq_sweep_if cpu_if ();

  ch1_freq_sweep dut (
    .ajer_2mhz     (clk),
    .apu_reset     (rst),
    .cpu           (cpu_if),
    .nff10_d3      (nff),
    .ch1_freq_tick (tk),
    .ch1_restart   (rs),
    .ch1_ld_shift  (ld),
    .ch1_shift_clk (sh),
    .ch1_freq_upd1 (u1),
    .ch1_freq_upd2 (u2),
    .freq          (freq),
    .copu          (copu),
    .atys          (atys)
  );

  typedef struct {
    string       name;
    logic [10:0] freq;
    logic        atys;
    logic        copu;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  task automatic expect_state(input string n, input logic [10:0] f,
                              input logic a, input logic c);
    exp_t e;
    e.name = n; e.freq = f; e.atys = a; e.copu = c;
    exp_q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_write(input logic s13, input logic s14, input logic [7:0] v);
    cpu_if.d = v; cpu_if.ff13 = s13; cpu_if.ff14 = s14; cpu_if.apu_wr = 1'b1;
    step();
    cpu_if.apu_wr = 1'b0; cpu_if.ff13 = 1'b0; cpu_if.ff14 = 1'b0;
  endtask

  task automatic set_freq(input logic [10:0] f);
    cpu_write(1'b1, 1'b0, f[7:0]);
    cpu_write(1'b0, 1'b1, {5'd0, f[10:8]});
  endtask

  // Raise the selected strobes for one cycle, then wait for the action cycle
  task automatic pulse(input logic [3:0] m);
    {u2, u1, sh, ld} = m;
    step();
    {u2, u1, sh, ld} = 4'b0000;
    step();
  endtask

  task automatic restart();
    rs = 1'b1; step(); rs = 1'b0;
  endtask

  task automatic tick();
    tk = 1'b1; step(); tk = 1'b0;
  endtask

  // Monitor: compares one expected record per falling edge
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      mon_e = exp_q.pop_front();
      checks++;
      if (freq !== mon_e.freq) begin
        errors++;
        $display("FAIL %s freq: got %h expected %h", mon_e.name, freq, mon_e.freq);
      end
      checks++;
      if (atys !== mon_e.atys) begin
        errors++;
        $display("FAIL %s atys: got %b expected %b", mon_e.name, atys, mon_e.atys);
      end
      checks++;
      if (copu !== mon_e.copu) begin
        errors++;
        $display("FAIL %s copu: got %b expected %b", mon_e.name, copu, mon_e.copu);
      end
    end
    if (stim_done) begin
      checks++;
      if (exp_q.size() != 0) begin
        errors++;
        $display("FAIL drain: got %0d pending expected 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
    end
  end

  initial begin
    rst = 1'b1;
    nff = 1'b1; tk = 1'b0; rs = 1'b0;
    ld = 1'b0; sh = 1'b0; u1 = 1'b0; u2 = 1'b0;
    cpu_if.d = 8'h00; cpu_if.apu_wr = 1'b0; cpu_if.ff13 = 1'b0; cpu_if.ff14 = 1'b0;
    #1;
    expect_state("reset", 11'h000, 1'b1, 1'b0);
    step();
    rst = 1'b0;

    // Near-maximum frequency: copu every second tick
    set_freq(11'h7FE);
    restart();
    expect_state("wr_freq", 11'h7FE, 1'b1, 1'b0);
    tick(); expect_state("tick1", 11'h7FE, 1'b1, 1'b0);
    tick(); expect_state("tick2", 11'h7FE, 1'b1, 1'b1);
    tick(); expect_state("tick3", 11'h7FE, 1'b1, 1'b0);
    tick(); expect_state("tick4", 11'h7FE, 1'b1, 1'b1);
    step(); expect_state("copu_width", 11'h7FE, 1'b1, 1'b0);

    // Asynchronous reset while copu is high
    tick(); tick();
    rst = 1'b1;
    expect_state("midreset", 11'h000, 1'b1, 1'b0);
    step();
    rst = 1'b0;

    // Sweep add, shift strobe held high for three cycles fires once
    nff = 1'b1;
    set_freq(11'h400);
    pulse(4'b0001);
    sh = 1'b1; step(); step(); step(); sh = 1'b0; step();
    pulse(4'b0100);
    expect_state("add_upd1", 11'h600, 1'b1, 1'b0);
    pulse(4'b0100);
    expect_state("add_ovf", 11'h600, 1'b0, 1'b0);
    restart();
    expect_state("restart_atys", 11'h600, 1'b1, 1'b0);

    // Sweep subtract
    nff = 1'b0;
    set_freq(11'h100);
    pulse(4'b0001);
    pulse(4'b0010);
    pulse(4'b0010);
    pulse(4'b0100);
    expect_state("sub_upd1", 11'h0C0, 1'b1, 1'b0);
    pulse(4'b1000);
    expect_state("sub_upd2", 11'h0C0, 1'b1, 1'b0);

    // Subtract wraps modulo 2^11
    set_freq(11'h100);
    pulse(4'b0001);
    set_freq(11'h010);
    pulse(4'b0100);
    expect_state("sub_wrap", 11'h710, 1'b1, 1'b0);

    // CPU low-byte write lands in the same cycle as an upd1 commit
    nff = 1'b1;
    set_freq(11'h300);
    pulse(4'b0001);
    u1 = 1'b1; step(); u1 = 1'b0;
    cpu_if.d = 8'h55; cpu_if.ff13 = 1'b1; cpu_if.apu_wr = 1'b1;
    step();
    cpu_if.apu_wr = 1'b0; cpu_if.ff13 = 1'b0;
    expect_state("cpu_wins", 11'h655, 1'b1, 1'b0);

    // Load and shift together: load wins, so subtract yields zero
    nff = 1'b0;
    pulse(4'b0011);
    pulse(4'b0100);
    expect_state("ld_wins", 11'h000, 1'b1, 1'b0);

    // Restart coincident with the wrapping tick after an overflow
    nff = 1'b1;
    set_freq(11'h7FE);
    restart();
    tick();
    pulse(4'b0001);
    pulse(4'b1000);
    expect_state("upd2_ovf", 11'h7FE, 1'b0, 1'b0);
    rs = 1'b1; tk = 1'b1; step(); rs = 1'b0; tk = 1'b0;
    expect_state("restart_tick", 11'h7FE, 1'b1, 1'b0);
    tick(); expect_state("post_rs_t1", 11'h7FE, 1'b1, 1'b0);
    tick(); expect_state("post_rs_t2", 11'h7FE, 1'b1, 1'b1);

    // Maximum frequency: copu on every tick
    set_freq(11'h7FF);
    restart();
    tick(); expect_state("f2047_t1", 11'h7FF, 1'b1, 1'b1);
    tick(); expect_state("f2047_t2", 11'h7FF, 1'b1, 1'b1);
    tick(); expect_state("f2047_t3", 11'h7FF, 1'b1, 1'b1);
    step(); expect_state("f2047_idle", 11'h7FF, 1'b1, 1'b0);

    stim_done = 1'b1;
  end

endmodule

`default_nettype wire
